// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - load-store unit bridging execute stage and data-memory bus
module lsu_riscv (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misaligned_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf_q;

    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        idle_req;
    logic [31:0] lane_shift;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode alignment, byte enables and lane-replicated store data from the incoming request
    always_comb begin
        misaligned = 1'b0;
        be_c       = 4'b0001 << lsu_addr_i[1:0];
        wdata_c    = {4{lsu_data_i[7:0]}};
        case (lsu_size_i)
            3'd1, 3'd5: begin
                misaligned = lsu_addr_i[0];
                be_c       = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_c    = {2{lsu_data_i[15:0]}};
            end
            3'd2: begin
                misaligned = |lsu_addr_i[1:0];
                be_c       = 4'b1111;
                wdata_c    = lsu_data_i;
            end
            default: ;
        endcase
    end

    // Access sequencer: latch request, hold it on the bus until granted, then await the response
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (misaligned) begin
                            // Clear the buffer so a faulting access never returns stale load data
                            rbuf_q <= 32'd0;
                            state  <= DONE;
                        end else begin
                            we_q    <= lsu_we_i;
                            size_q  <= lsu_size_i;
                            addr_q  <= lsu_addr_i;
                            be_q    <= be_c;
                            wdata_q <= wdata_c;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) state <= WAIT;
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        rbuf_q <= data_rdata_i;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the addressed lane of the read buffer and extend it to 32 bits
    always_comb begin
        lane_shift = rbuf_q >> {addr_q[1:0], 3'b000};
        half_sel   = addr_q[1] ? rbuf_q[31:16] : rbuf_q[15:0];
        case (size_q)
            3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_ext = {16'd0, half_sel};
            3'd2:    load_ext = rbuf_q;
            3'd4:    load_ext = {24'd0, lane_shift[7:0]};
            default: load_ext = {{24{lane_shift[7]}}, lane_shift[7:0]};
        endcase
    end

    // Drive core and bus outputs from the current state; everything idles at zero
    always_comb begin
        idle_req         = (state == IDLE) && lsu_req_i;
        lsu_stall_req_o  = (idle_req && !misaligned) || (state == REQ) || (state == WAIT);
        lsu_misaligned_o = idle_req && misaligned;
        data_req_o       = (state == REQ);
        data_we_o        = (state == REQ) && we_q;
        data_be_o        = (state == REQ) ? be_q : 4'd0;
        data_addr_o      = (state == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
        data_wdata_o     = (state == REQ) ? wdata_q : 32'd0;
        lsu_data_o       = ((state == DONE) && !we_q) ? load_ext : 32'd0;
    end

endmodule

// File: tb/tb_lsu_riscv.sv
// tb/tb_lsu_riscv.sv - self-checking scoreboard bench for lsu_riscv
module tb_lsu_riscv;

    logic        clk_i;
    logic        arstn_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_misaligned_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_grants = 0;

    lsu_riscv dut (
        .clk_i            (clk_i),
        .arstn_i          (arstn_i),
        .lsu_req_i        (lsu_req_i),
        .lsu_we_i         (lsu_we_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_data_i       (lsu_data_i),
        .lsu_data_o       (lsu_data_o),
        .lsu_stall_req_o  (lsu_stall_req_o),
        .lsu_misaligned_o (lsu_misaligned_o),
        .data_req_o       (data_req_o),
        .data_we_o        (data_we_o),
        .data_be_o        (data_be_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_gnt_i       (data_gnt_i),
        .data_rvalid_i    (data_rvalid_i),
        .data_rdata_i     (data_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_stall"}, {31'd0, lsu_stall_req_o}, 32'd0);
        check({tag, "_req"},   {31'd0, data_req_o}, 32'd0);
        check({tag, "_we"},    {31'd0, data_we_o}, 32'd0);
        check({tag, "_be"},    {28'd0, data_be_o}, 32'd0);
        check({tag, "_addr"},  data_addr_o, 32'd0);
        check({tag, "_wdata"}, data_wdata_o, 32'd0);
        check({tag, "_data"},  lsu_data_o, 32'd0);
        check({tag, "_mis"},   {31'd0, lsu_misaligned_o}, 32'd0);
    endtask

    // Issue one aligned access (caller is just past a rising edge) and act as the bus
    task automatic do_access(input string tag, input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int gd, input int rd, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_data);
        exp_t e;
        exp_t r;
        int   stalls = 0;
        int   reqc   = 0;
        int   waitc  = 0;
        int   cyc    = 0;
        int   grants = 0;
        bit   done   = 0;
        e.we     = we;
        e.be     = exp_be;
        e.addr   = {addr[31:2], 2'b00};
        e.wdata  = exp_wdata;
        e.data   = exp_data;
        e.stalls = 3 + gd + rd;
        exp_q.push_back(e);
        lsu_req_i  = 1'b1;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = wdata;
        while (!done && cyc < 60) begin
            @(negedge clk_i);
            cyc++;
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (lsu_stall_req_o) stalls++;
            if (data_req_o) begin
                check({tag, "_addr"},  data_addr_o, e.addr);
                check({tag, "_be"},    {28'd0, data_be_o}, {28'd0, e.be});
                check({tag, "_wdata"}, data_wdata_o, e.wdata);
                check({tag, "_we"},    {31'd0, data_we_o}, {31'd0, e.we});
                if (reqc == gd) begin
                    data_gnt_i = 1'b1;
                    grants++;
                    n_grants++;
                end
                reqc++;
            end else if (lsu_stall_req_o && reqc > 0) begin
                if (waitc == rd) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rdata;
                end
                waitc++;
            end else if (!lsu_stall_req_o && cyc > 1) begin
                done = 1;
                r = exp_q.pop_front();
                check({tag, "_ldata"},  lsu_data_o, r.data);
                check({tag, "_stalls"}, stalls, r.stalls);
                check({tag, "_grants"}, grants, 1);
            end
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        @(posedge clk_i);
        #1;
        lsu_req_i     = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        int g0;
        arstn_i       = 1'b0;
        lsu_req_i     = 1'b0;
        lsu_we_i      = 1'b0;
        lsu_size_i    = 3'd0;
        lsu_addr_i    = 32'd0;
        lsu_data_i    = 32'd0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_idle_outputs("reset");
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        do_access("lw", 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
                  4'b1111, 32'h0, 32'hDEADBEEF);
        do_access("lb", 1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000,
                  4'b1000, 32'h0, 32'hFFFFFF80);
        do_access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 1, 1, 32'h80FF_0000,
                  4'b1000, 32'h0, 32'h00000080);
        do_access("lhu", 1'b0, 3'd5, 32'h502, 32'h0, 0, 1, 32'hF00D_1234,
                  4'b1100, 32'h0, 32'h0000F00D);
        do_access("sh", 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 3, 0, 32'h0,
                  4'b1100, 32'hABCDABCD, 32'h0);
        do_access("sb", 1'b1, 3'd0, 32'h601, 32'h0000005A, 0, 0, 32'h0,
                  4'b0010, 32'h5A5A5A5A, 32'h0);

        // Misaligned word: flag for one cycle, no bus traffic, no stall
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'd2;
        lsu_addr_i = 32'h101;
        @(negedge clk_i);
        check("mis_flag",  {31'd0, lsu_misaligned_o}, 32'd1);
        check("mis_stall", {31'd0, lsu_stall_req_o}, 32'd0);
        check("mis_req",   {31'd0, data_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        check("mis_flag_done", {31'd0, lsu_misaligned_o}, 32'd0);
        check("mis_req_done",  {31'd0, data_req_o}, 32'd0);
        check("mis_stall_done", {31'd0, lsu_stall_req_o}, 32'd0);
        @(posedge clk_i);
        #1;

        // Reset while waiting for the response, then a stray rvalid
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_size_i = 3'd2;
        lsu_addr_i = 32'h400;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_pre_req", {31'd0, data_req_o}, 32'd1);
        data_gnt_i = 1'b1;
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        check("rst_pre_wait_stall", {31'd0, lsu_stall_req_o}, 32'd1);
        arstn_i   = 1'b0;
        lsu_req_i = 1'b0;
        #1;
        check_idle_outputs("rst_mid_wait");
        @(posedge clk_i);
        #1;
        arstn_i       = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h5555_5555;
        @(negedge clk_i);
        check("rst_late_rv_stall", {31'd0, lsu_stall_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        data_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("rst_late_rv_data", lsu_data_o, 32'd0);
        @(posedge clk_i);
        #1;
        do_access("lw_after_rst", 1'b0, 3'd2, 32'h400, 32'h0, 0, 0, 32'h0BAD_CAFE,
                  4'b1111, 32'h0, 32'h0BAD_CAFE);

        // Back-to-back store then load
        g0 = n_grants;
        do_access("b2b_sw", 1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 0, 0, 32'h0,
                  4'b1111, 32'hCAFEF00D, 32'h0);
        do_access("b2b_lh", 1'b0, 3'd1, 32'h302, 32'h0, 0, 2, 32'h8001_1234,
                  4'b1100, 32'h0, 32'hFFFF8001);
        check("b2b_bus_requests", n_grants - g0, 2);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_riscv.md
# lsu_riscv

Load-store unit between the core's execute stage and the data-memory bus. It takes the decoder's memory request, size and write-enable together with the ALU-computed address and the rs2 store data. It runs a request/grant/response handshake on the data bus and holds `lsu_stall_req_o` high until the access completes. On completion it returns sign- or zero-extended load data for write-back.

## Interface
- Parameters: none. Bus and address widths are fixed at 32.
- `clk_i` in 1: core clock.
- `arstn_i` in 1: asynchronous active-low reset.
- `lsu_req_i` in 1: memory access requested by the current instruction (decoder `mem_req_o`).
- `lsu_we_i` in 1: 1 = store, 0 = load.
- `lsu_size_i` in 3: size code. 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- `lsu_addr_i` in 32: byte address.
- `lsu_data_i` in 32: store data (rs2).
- `lsu_data_o` out 32: extended load data. Valid only in the completion cycle.
- `lsu_stall_req_o` out 1: stall request to the core (drives decoder `lsu_stall_req_i`).
- `lsu_misaligned_o` out 1: misaligned access flag, one cycle.
- `data_req_o` out 1: bus request.
- `data_we_o` out 1: bus write enable.
- `data_be_o` out 4: byte enables.
- `data_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `data_wdata_o` out 32: lane-replicated store data.
- `data_gnt_i` in 1: bus grant. Accepted only while `data_req_o` = 1.
- `data_rvalid_i` in 1: response valid (load data, or store acknowledge).
- `data_rdata_i` in 32: response data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - `lsu_req_i` = 1 and aligned: latch addr, we, size, be and wdata; go to REQ.
  - `lsu_req_i` = 1 and misaligned: pulse `lsu_misaligned_o` = 1, no bus traffic; go to DONE.
  - Otherwise stay in IDLE.
- **Misalignment:** H/HU with `addr[0]` = 1, or W with `addr[1:0]` != 0.
- **REQ:** `data_req_o` = 1 with the latched fields held stable. `data_gnt_i` = 1 → WAIT; otherwise stay in REQ.
- **WAIT:** `data_req_o` = 0. `data_rvalid_i` = 1 → capture `data_rdata_i` into the read buffer and go to DONE. `data_rvalid_i` is ignored in every state except WAIT.
- **DONE:** stall is low. `lsu_data_o` is driven from the read buffer. `lsu_req_i` is ignored (it belongs to the retiring instruction). Always go to IDLE.
- **`lsu_stall_req_o`:** 1 in IDLE when `lsu_req_i` = 1 and the access is aligned; 1 in REQ and in WAIT; 0 otherwise.
- **Byte enables**
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
  - Undefined size codes: treated as B.
- **Write data**
  - B: `{4{data[7:0]}}`.
  - H: `{2{data[15:0]}}`.
  - W: `data`.
- **Load extension:** select the lane using the latched `addr[1:0]`.
  - B: sign-extend byte. BU: zero-extend byte.
  - H: sign-extend half. HU: zero-extend half.
  - W: full word.
- **Stores:** `lsu_data_o` = 0.
- **Defaults:**
  - Outputs not asserted by the current state are 0.
  - `lsu_data_o` = 0 outside DONE.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, latches and read buffer cleared.
- `arstn_i` low at any time, including mid-REQ or mid-WAIT, aborts immediately with no bus retry. A late `data_rvalid_i` after reset is ignored, because the FSM is in IDLE.
- **Minimum aligned access (gnt in REQ cycle, rvalid one cycle later):** 4 cycles.
  - c0: IDLE, stall = 1.
  - c1: REQ, stall = 1.
  - c2: WAIT, stall = 1.
  - c3: DONE, stall = 0, data valid, write-back.
- Each cycle of grant wait or response wait adds one stall cycle.
- A misaligned access takes 2 cycles: c0 stall = 0, flag = 1; c1 DONE.
- `data_gnt_i` and `data_rvalid_i` arriving in the same REQ cycle: the rvalid is ignored. The bus guarantees rvalid no earlier than the cycle after gnt.
- Back-to-back accesses: the second request is sampled in the IDLE cycle after DONE, so there is no overlap.

## Test plan
- **LW, aligned:** `addr=0x100`, immediate gnt, rvalid next cycle with `rdata=0xDEADBEEF` → `be=1111`, `data_addr_o=0x100`, stall high for exactly 3 cycles, `lsu_data_o=0xDEADBEEF` in DONE.
- **LB/LBU at `addr=0x103`**, `rdata=0x80FF_0000` → `be=1000`; LB returns `0xFFFFFF80`, LBU returns `0x00000080`.
- **SH at `addr=0x202`**, `data=0x1234ABCD`, gnt delayed 3 cycles → `be=1100`, `wdata=0xABCDABCD`; address, be and wdata stable across all REQ cycles; stall high for 6 cycles.
- **LW at `addr=0x101`** → `lsu_misaligned_o=1` for 1 cycle, `data_req_o` never asserted, stall stays 0.
- **Reset mid-WAIT** (`arstn_i` low for 1 cycle) → all outputs 0 at once; a subsequent rvalid is ignored; the next LW completes normally.
- **Back-to-back SW then LH** with rvalid delays of 0 and 2 cycles → exactly two bus requests; the LH returns the sign-extended half.
